// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage with a wait-stated word memory and a stall FSM.
// Optional build macro MEM_MISALIGN_CHECK_EN rejects requests whose byte address is not word aligned.
module mem_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic [31:0] address_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  reg_dest_in,
    output logic        stall,
    output logic        mem_to_reg_out,
    output logic        reg_write_out,
    output logic [31:0] read_data_out,
    output logic [31:0] address_out,
    output logic [4:0]  reg_dest_out,
    output logic        misalign_out
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [2:0]    wait_cnt_r;
    logic [31:0]   req_addr_r;
    logic [31:0]   req_wdata_r;
    logic          req_rd_r;
    logic          req_wr_r;
    logic [31:0]   rd_q_r;
    logic [31:0]   mem_r [DEPTH_WORDS];

    logic          req_s;
    logic          misalign_s;
    logic          start_s;
    logic          access_s;
    logic          stall_s;
    logic [AW-1:0] req_idx_s;

    assign req_s = mem_read_in | mem_write_in;
`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_s = req_s && (address_in[1:0] != 2'b00) && (state_r == IDLE);
`else
    assign misalign_s = 1'b0;
`endif
    assign start_s   = (state_r == IDLE) && req_s && !misalign_s;
    assign access_s  = (state_r == BUSY) && (wait_cnt_r == 3'd0);
    assign stall_s   = start_s || (state_r == BUSY);
    assign req_idx_s = req_addr_r[AW+1:2];

    // Next-state selection: one pass IDLE -> BUSY -> DONE -> IDLE per access.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (access_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Stage outputs: pass-through, with a bubble on control bits while stalled or rejected.
    always_comb begin
        stall          = stall_s;
        reg_write_out  = reg_write_in & ~stall_s & ~misalign_s;
        mem_to_reg_out = mem_to_reg_in & ~stall_s & ~misalign_s;
        reg_dest_out   = reg_dest_in;
        misalign_out   = misalign_s;
        address_out    = address_in;
        read_data_out  = 32'd0;
        if (state_r == DONE) begin
            address_out   = req_addr_r;
            read_data_out = (req_rd_r && !req_wr_r) ? rd_q_r : 32'd0;
        end else begin
            address_out   = address_in;
            read_data_out = 32'd0;
        end
    end

    // FSM state, wait counter, latched request and load data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 3'd0;
            req_addr_r  <= 32'd0;
            req_wdata_r <= 32'd0;
            req_rd_r    <= 1'b0;
            req_wr_r    <= 1'b0;
            rd_q_r      <= 32'd0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        req_addr_r  <= address_in;
                        req_wdata_r <= write_data_in;
                        req_rd_r    <= mem_read_in;
                        req_wr_r    <= mem_write_in;
                        wait_cnt_r  <= WAIT_INIT;
                    end
                end
                BUSY: begin
                    if (wait_cnt_r != 3'd0) begin
                        wait_cnt_r <= wait_cnt_r - 3'd1;
                    end else if (req_rd_r && !req_wr_r) begin
                        rd_q_r <= mem_r[req_idx_s];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Data memory write port; reset on the access edge cancels the store.
    always_ff @(posedge clk) begin
        if (!rst && access_s && req_wr_r) begin
            mem_r[req_idx_s] <= req_wdata_r;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level model predicts every cycle's outputs.
module tb_mem_stage;
    localparam int DEPTH = 256;
    localparam int W     = 2;
    localparam int AW    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
    logic [31:0] address_in, write_data_in;
    logic [4:0]  reg_dest_in;
    logic        stall, mem_to_reg_out, reg_write_out, misalign_out;
    logic [31:0] read_data_out, address_out;
    logic [4:0]  reg_dest_out;

    mem_stage #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(W)) dut (
        .clk(clk), .rst(rst),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .address_in(address_in), .write_data_in(write_data_in), .reg_dest_in(reg_dest_in),
        .stall(stall), .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
        .read_data_out(read_data_out), .address_out(address_out),
        .reg_dest_out(reg_dest_out), .misalign_out(misalign_out)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [DEPTH];
    bit          model_valid [DEPTH];

    bit          chk_en = 1'b0;
    logic        e_stall, e_rw, e_m2r, e_mis;
    logic [31:0] e_rd, e_addr;
    logic [4:0]  e_dest;
    bit          e_rd_known;
    int          stall_run = 0;
    int          last_run  = 0;
    logic [31:0] done_rd = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall), 32'(e_stall));
            check("reg_write_out", 32'(reg_write_out), 32'(e_rw));
            check("mem_to_reg_out", 32'(mem_to_reg_out), 32'(e_m2r));
            check("misalign_out", 32'(misalign_out), 32'(e_mis));
            check("address_out", address_out, e_addr);
            check("reg_dest_out", 32'(reg_dest_out), 32'(e_dest));
            if (e_rd_known) check("read_data_out", read_data_out, e_rd);
            if (stall === 1'b1) begin
                stall_run++;
            end else begin
                if (stall_run != 0) last_run = stall_run;
                stall_run = 0;
            end
            done_rd = read_data_out;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] dest);
        mem_read_in   = rd;
        mem_write_in  = wr;
        mem_to_reg_in = m2r;
        reg_write_in  = rw;
        address_in    = addr;
        write_data_in = wdata;
        reg_dest_in   = dest;
    endtask

    task automatic expect_cycle(input logic st, input logic rw, input logic m2r, input logic mis,
                                input logic [31:0] rdat, input logic [31:0] addr,
                                input logic [4:0] dest, input bit known);
        e_stall    = st;
        e_rw       = rw;
        e_m2r      = m2r;
        e_mis      = mis;
        e_rd       = rdat;
        e_addr     = addr;
        e_dest     = dest;
        e_rd_known = known;
    endtask

    task automatic do_nop(input logic rw, input logic m2r, input logic [31:0] addr, input logic [4:0] dest);
        drive(1'b0, 1'b0, m2r, rw, addr, $urandom, dest);
        expect_cycle(1'b0, rw, m2r, 1'b0, 32'd0, addr, dest, 1'b1);
        next_cycle();
    endtask

    // One load/store: WAIT_STATES+2 stalled bubble cycles, then one result cycle.
    task automatic do_mem(input logic rd, input logic wr, input logic m2r, input logic rw,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] dest);
        int idx;
        idx = int'(addr[AW+1:2]);
        drive(rd, wr, m2r, rw, addr, wdata, dest);
        last_run = 0;
`ifdef MEM_MISALIGN_CHECK_EN
        if (addr[1:0] != 2'b00) begin
            expect_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, addr, dest, 1'b1);
            next_cycle();
            return;
        end
`endif
        for (int k = 0; k < W + 2; k++) begin
            expect_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, addr, dest, 1'b1);
            next_cycle();
        end
        expect_cycle(1'b0, rw, m2r, 1'b0, wr ? 32'd0 : model_mem[idx], addr, dest,
                     wr || model_valid[idx]);
        next_cycle();
        check("stall_len", 32'(last_run), 32'(W + 2));
        if (wr) begin
            model_mem[idx]   = wdata;
            model_valid[idx] = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        do_nop(1'b1, 1'b0, 32'h0000_1234, 5'd5);
        check("nop_rd_lit", done_rd, 32'd0);

        do_mem(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 5'd0);
        check("store_rd_lit", done_rd, 32'd0);
        do_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'd0, 5'd8);
        check("load40_lit", done_rd, 32'hDEAD_BEEF);
        do_nop(1'b0, 1'b0, 32'h0000_0044, 5'd0);

        do_mem(1'b0, 1'b1, 1'b0, 1'b0, 32'(4 * DEPTH + 8), 32'hA5A5_A5A5, 5'd0);
        do_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'd0, 5'd3);
        check("wrap_lit", done_rd, 32'hA5A5_A5A5);

        do_mem(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_000C, 32'h1234_5678, 5'd2);
        check("both_rd_lit", done_rd, 32'd0);

        // Store aborted by reset on its final BUSY edge.
        do_mem(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'hCAFE_0010, 5'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h1111_1111, 5'd0);
        for (int k = 0; k < W + 1; k++) begin
            expect_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_0010, 5'd0, 1'b1);
            next_cycle();
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0077, 32'd0, 5'd7);
        expect_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_0077, 5'd7, 1'b1);
        next_cycle();
        rst = 1'b0;
        do_nop(1'b1, 1'b0, 32'h0000_0078, 5'd7);
        do_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'd0, 5'd9);
        check("abort_lit", done_rd, 32'hCAFE_0010);

        do_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0042, 32'd0, 5'd4);
`ifdef MEM_MISALIGN_CHECK_EN
        check("misalign_rd_lit", done_rd, 32'd0);
`else
        check("misalign_rd_lit", done_rd, 32'hDEAD_BEEF);
`endif

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            int          kind;
            a = $urandom;
            a[AW+1:2] = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: do_nop(1'($urandom), 1'($urandom), a, 5'($urandom));
                1: do_mem(1'b1, 1'b0, 1'($urandom), 1'($urandom), a, $urandom, 5'($urandom));
                2: do_mem(1'b0, 1'b1, 1'($urandom), 1'($urandom), a, $urandom, 5'($urandom));
                default: do_mem(1'b1, 1'b1, 1'($urandom), 1'($urandom), a, $urandom, 5'($urandom));
            endcase
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
